key_press_gen: RTL and testbench
================================

Name: key_press_gen

Overview:
- Key-press stimulus transmitter: drives an emulated mechanical push-button line, active-low, idle high.
- On command it produces one complete press: a bouncy falling edge, a clean low hold, a bouncy rising edge, then a clean return to idle.
- Feeds the board's key-input/debounce logic for hardware-in-loop self-test, and counts completed presses.

Parameters:
- BOUNCE_CNT, 2, number of glitch pairs in each bounce phase; 0 disables bounce.
- BOUNCE_PER, 3, clk cycles per bounce segment; must be >= 1.
- HOLD_W, 10, width of the hold_len input.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  request one press; sampled only when idle.
- hold_len  input  HOLD_W  clean-low hold length in cycles; latched on accepted start.
- key_out  output  1  emulated key line; 1 = released, 0 = pressed.
- busy  output  1  high while a press is being generated.
- done  output  1  one-cycle pulse when a press completes.
- presses  output  10  completed-press counter, wraps 1023 -> 0.

Behaviour:
- Reset (rst=0 at a posedge):
  - key_out=1, busy=0, done=0, presses=0, state IDLE, internal counters cleared.
  - Reset has priority over everything else, including mid-operation.
  - key_out returns high at that same edge.
- States: IDLE, PRESS_B, HOLD, REL_B.
- Segment counter: counts BOUNCE_PER cycles per segment. Segment index k runs 0 .. 2*BOUNCE_CNT-1.
- IDLE:
  - key_out=1, busy=0.
  - If start=1 at an edge: latch hold_len (a latched value of 0 is treated as 1), busy=1.
  - Go to PRESS_B; if BOUNCE_CNT=0, go straight to HOLD.
  - key_out=0 from that edge.
- PRESS_B:
  - key_out=0 for even k, 1 for odd k.
  - After 2*BOUNCE_CNT segments, go to HOLD with key_out=0.
- HOLD:
  - key_out=0 for exactly the latched hold length in cycles.
  - Then go to REL_B; if BOUNCE_CNT=0, go straight to IDLE.
- REL_B:
  - key_out=1 for even k, 0 for odd k.
  - After 2*BOUNCE_CNT segments, go to IDLE.
- Entering IDLE from an active state:
  - key_out=1, busy=0, done=1 for exactly that one cycle.
  - presses increments at the same edge, modulo 1024.
- Timing: with the start-accept edge as E0, busy is high for 4*BOUNCE_CNT*BOUNCE_PER + H cycles (H = max(hold_len,1)). done and the idle key_out=1 appear in the following cycle.
- start while busy is ignored; there is no queueing.
- start held high continuously gives back-to-back presses:
  - The done cycle is IDLE, so start is accepted at the next edge.
  - Exactly one clean key_out=1 cycle separates the two presses.
- hold_len changes after acceptance have no effect on the current press.
- key_out is a registered output, with no combinational path from start.
- Outputs never show X after the first reset edge.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> key_out=1, busy=0, done=0, presses=0; no press starts while rst=0.
- Defaults, hold_len=20, 1-cycle start pulse accepted at E0, cycles counted from E0 (cycle 0 = first cycle after E0):
  - key_out: low cycles 0-2, high 3-5, low 6-8, high 9-11, low 12-31, high 32-34, low 35-37, high 38-40, low 41-43.
  - Cycle 44: key_out=1, busy=0, done=1 for that one cycle, presses=1.
- hold_len=0 -> clean-low hold lasts exactly 1 cycle; busy high for 25 cycles; done on cycle 25.
- start held high for 3 presses, hold_len=5 -> each press busy for 29 cycles; a single high idle cycle with done=1 between presses; presses=3; extra start pulses while busy do not alter the waveform.
- Reset mid-operation: rst=0 during HOLD, cycle 15 -> key_out=1 and busy=0 at that edge, no done pulse, presses unchanged; the next start produces a full normal press.
- BOUNCE_CNT=0, hold_len=7 -> key_out low for exactly 7 cycles with no glitches; done on cycle 7. Separately, run 1025 presses -> presses wraps to 1.

Source files
------------

// File: rtl/key_press_gen.sv
// key_press_gen: emulated mechanical push-button transmitter.
//
// On an accepted start it drives key_out through one complete press:
// a bouncy falling edge, a clean low hold, a bouncy rising edge, and a
// clean return to idle. It also counts completed presses. The line is
// active-low and idles high.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous active-low reset
//   start    in   request one press, sampled only while idle
//   hold_len in   clean-low hold length in cycles, latched on accepted start
//   key_out  out  emulated key line (1 = released, 0 = pressed), registered
//   busy     out  high while a press is being generated
//   done     out  one-cycle pulse on the first idle cycle after a press
//   presses  out  completed-press counter, wraps 1023 -> 0
module key_press_gen #(
    parameter int unsigned BOUNCE_CNT = 2,
    parameter int unsigned BOUNCE_PER = 3,
    parameter int unsigned HOLD_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              key_out,
    output logic              busy,
    output logic              done,
    output logic [9:0]        presses
);

    // Cycle counter within one bounce segment, and segment index k.
    localparam int unsigned SEG_W = (BOUNCE_PER > 1) ? $clog2(BOUNCE_PER) : 1;
    localparam int unsigned NSEG  = 2 * BOUNCE_CNT;
    localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [SEG_W-1:0] SEG_LAST  = SEG_W'(BOUNCE_PER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'((NSEG > 0) ? NSEG - 1 : 0);
    localparam bit               NO_BOUNCE = (BOUNCE_CNT == 0);

    typedef enum logic [1:0] {
        StIdle,
        StPressB,
        StHold,
        StRelB
    } state_e;

    state_e             state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               key_q, key_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [9:0]         presses_q, presses_d;

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero hold request still yields a one-cycle clean low.
                    hold_d     = (hold_len == '0) ? HOLD_W'(1) : hold_len;
                    seg_d      = '0;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    state_d    = NO_BOUNCE ? StHold : StPressB;
                end
            end

            StPressB: begin
                if (seg_q == SEG_LAST) begin
                    seg_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StHold;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                end
            end

            StHold: begin
                if (hold_cnt_q == hold_q - HOLD_W'(1)) begin
                    hold_cnt_d = '0;
                    state_d    = NO_BOUNCE ? StIdle : StRelB;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            StRelB: begin
                if (seg_q == SEG_LAST) begin
                    seg_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered; their next values derive from the next state
    // so the line changes on the same edge the state does.
    always_comb begin
        key_d     = 1'b1;
        busy_d    = (state_d != StIdle);
        done_d    = (state_q != StIdle) && (state_d == StIdle);
        presses_d = presses_q + {9'd0, done_d};

        unique case (state_d)
            StPressB: key_d = idx_d[0];   // even segment low, odd high
            StHold:   key_d = 1'b0;
            StRelB:   key_d = ~idx_d[0];  // even segment high, odd low
            default:  key_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            seg_q      <= '0;
            idx_q      <= '0;
            hold_q     <= HOLD_W'(1);
            hold_cnt_q <= '0;
            key_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            presses_q  <= '0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            presses_q  <= presses_d;
        end
    end

    assign key_out = key_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign presses = presses_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Testbench for key_press_gen: two instances (default bounce and no bounce)
// share one stimulus stream. A reference model computes the expected
// waveform per press arithmetically and pushes per-cycle expectations into
// queues; a monitor pops and compares on every falling edge.
module tb_key_press_gen;

    localparam int PER = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] hold_len;

    logic       key_a, busy_a, done_a;
    logic [9:0] presses_a;
    logic       key_b, busy_b, done_b;
    logic [9:0] presses_b;

    int tests;
    int fails;

    key_press_gen #(
        .BOUNCE_CNT(2),
        .BOUNCE_PER(PER),
        .HOLD_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .hold_len(hold_len),
        .key_out(key_a),
        .busy(busy_a),
        .done(done_a),
        .presses(presses_a)
    );

    key_press_gen #(
        .BOUNCE_CNT(0),
        .BOUNCE_PER(PER),
        .HOLD_W(10)
    ) dut_nb (
        .clk(clk),
        .rst(rst),
        .start(start),
        .hold_len(hold_len),
        .key_out(key_b),
        .busy(busy_b),
        .done(done_b),
        .presses(presses_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = default bounce, 1 = no bounce.
    int bc[2] = '{2, 0};
    bit active[2];
    int tt[2];
    int len[2];
    int hh[2];
    int pc[2];

    // Expected entries: {key_out, busy, done, presses}.
    logic [12:0] exp_a[$];
    logic [12:0] exp_b[$];

    // Key level at offset t into a press: bounce pairs, clean hold, bounce.
    function automatic bit key_at(int t, int b, int h);
        int bl;
        bl = 2 * b * PER;
        if (t < bl) return ((t / PER) % 2) != 0;
        t = t - bl;
        if (t < h) return 1'b0;
        t = t - h;
        return ((t / PER) % 2) == 0;
    endfunction

    task automatic push_exp(input int i, input bit k, input bit b, input bit d);
        logic [12:0] e;
        logic [9:0]  p;
        p = pc[i][9:0];
        e = {k, b, d, p};
        if (i == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic model(input int i, input bit r, input bit s, input int h);
        if (!r) begin
            active[i] = 1'b0;
            pc[i]     = 0;
            push_exp(i, 1'b1, 1'b0, 1'b0);
        end else if (active[i]) begin
            tt[i] = tt[i] + 1;
            if (tt[i] < len[i]) begin
                push_exp(i, key_at(tt[i], bc[i], hh[i]), 1'b1, 1'b0);
            end else begin
                active[i] = 1'b0;
                pc[i]     = (pc[i] + 1) % 1024;
                push_exp(i, 1'b1, 1'b0, 1'b1);
            end
        end else if (s) begin
            active[i] = 1'b1;
            tt[i]     = 0;
            hh[i]     = (h == 0) ? 1 : h;
            len[i]    = 4 * bc[i] * PER + hh[i];
            push_exp(i, key_at(0, bc[i], hh[i]), 1'b1, 1'b0);
        end else begin
            push_exp(i, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Drive one cycle of inputs, record expectations, advance to next negedge.
    task automatic step(input bit r, input bit s, input int h);
        rst      = r;
        start    = s;
        hold_len = h[9:0];
        model(0, r, s, h);
        model(1, r, s, h);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got key=%b busy=%b done=%b presses=%0d, want key=%b busy=%b done=%b presses=%0d",
                     name, $time, act[12], act[11], act[10], act[9:0],
                     exp[12], exp[11], exp[10], exp[9:0]);
        end
    endtask

    // Monitor: one expectation per DUT per clock.
    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            check("bounce2", {key_a, busy_a, done_a, presses_a}, e);
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            check("bounce0", {key_b, busy_b, done_b, presses_b}, e);
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        start    = 1'b0;
        hold_len = '0;

        // Reset held with start asserted.
        repeat (3) step(1'b0, 1'b1, 20);

        // Default press, hold 20; hold_len changes afterwards must not matter.
        step(1'b1, 1'b1, 20);
        repeat (50) step(1'b1, 1'b0, $urandom_range(0, 63));

        // Zero hold length.
        step(1'b1, 1'b1, 0);
        repeat (30) step(1'b1, 1'b0, 0);

        // start held high: back-to-back presses.
        repeat (90) step(1'b1, 1'b1, 5);
        repeat (10) step(1'b1, 1'b0, 5);

        // Reset in the middle of the hold, then a clean press.
        step(1'b1, 1'b1, 20);
        repeat (14) step(1'b1, 1'b0, 20);
        step(1'b0, 1'b0, 20);
        repeat (3) step(1'b1, 1'b0, 20);
        step(1'b1, 1'b1, 20);
        repeat (50) step(1'b1, 1'b0, 20);

        // Random traffic: starts while busy, varying hold, rare resets.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 30)));
        end

        // Counter wrap on the no-bounce instance: 1025 presses.
        step(1'b0, 1'b0, 0);
        for (int n = 0; n < 2050; n++) step(1'b1, 1'b1, 0);
        step(1'b1, 1'b0, 0);
        tests++;
        if (presses_b !== 10'd1) begin
            fails++;
            $display("FAIL wrap: presses=%0d, want 1", presses_b);
        end

        step(1'b1, 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
